// File: rtl/firefly_pulse_meter.sv
// firefly_pulse_meter
//   Measures the high time and period of each full cycle of an asynchronous
//   square wave (the firefly divider output f1). It publishes one result per
//   rising-edge-to-rising-edge cycle, together with a one-cycle strobe.
//   Optional feature macro: GLITCH_FILTER_EN inserts a FILT_LEN-cycle stability
//   filter between the synchronizer and the edge detector.
module firefly_pulse_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_in,
    input  logic             clr,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_level_p0;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]       r_hreg;
    logic                   w_cap_high;
    logic                   w_publish;
    logic                   w_set_ovf;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_ovf;

    // Input synchronizer: f_in enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], f_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic            r_filt;
    logic [FC_W-1:0] r_fcnt;

    // Stability filter: follow the synchronized level only after it has differed for FILT_LEN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_sync != r_filt) begin
            if (r_fcnt == FC_W'(FILT_LEN - 1)) begin
                r_filt <= w_sync;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    // FILT_LEN only sizes the optional filter; it is referenced here to keep the parameter live.
    logic w_unused_filt_len;
    assign w_unused_filt_len = (FILT_LEN > 0);
    assign w_level           = w_sync;
`endif

    // Edge detector: delayed copy of the conditioned level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_p0 <= 1'b0;
        end else begin
            r_level_p0 <= w_level;
        end
    end

    assign w_rise = w_level & ~r_level_p0;
    assign w_fall = ~w_level & r_level_p0;

    // Cycle counter: restarts at 1 on each rise and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (w_rise) begin
            r_pcnt <= CNT_W'(1);
        end else if (r_pcnt != CNT_MAX) begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // High-time capture taken at the falling edge, published at the following rise.
    always_ff @(posedge clk) begin
        if (w_cap_high) begin
            r_hreg <= r_pcnt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and control; clr beats saturation, saturation beats edges.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_high  = 1'b0;
        w_publish   = 1'b0;
        w_set_ovf   = 1'b0;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (r_pcnt == CNT_MAX) begin
                        w_state_nxt = S_IDLE;
                        w_set_ovf   = 1'b1;
                    end else if (w_fall) begin
                        w_state_nxt = S_LOW;
                        w_cap_high  = 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_pcnt == CNT_MAX) begin
                        w_state_nxt = S_IDLE;
                        w_set_ovf   = 1'b1;
                    end else if (w_rise) begin
                        w_state_nxt = S_HIGH;
                        w_publish   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Result registers: update on publish, hold otherwise, cleared by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (clr) begin
                r_high   <= '0;
                r_period <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_publish) begin
                    r_high   <= r_hreg;
                    r_period <= r_pcnt;
                end
                if (w_set_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign high_cnt   = r_high;
    assign period_cnt = r_period;
    assign meas_valid = r_valid;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_firefly_pulse_meter.sv
// tb_firefly_pulse_meter
//   Directed bench for firefly_pulse_meter with a timestamp-based reference
//   model compared every clock, plus literal expectations per scenario.
//   Honours GLITCH_FILTER_EN in the same way as the design.
module tb_firefly_pulse_meter;

    localparam int CW   = 16;
    localparam int SYNC = 2;
    localparam int FL   = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_in  = 1'b0;
    logic          clr   = 1'b0;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic          meas_valid;
    logic          overflow;

    int n_chk = 0;
    int n_err = 0;
    int q_high[$];
    int q_period[$];

    firefly_pulse_meter #(
        .CNT_W      (CW),
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_in      (f_in),
        .clr       (clr),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .meas_valid(meas_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int qh(input int i);
        return (i < q_high.size()) ? q_high[i] : -1;
    endfunction

    function automatic int qp(input int i);
        return (i < q_period.size()) ? q_period[i] : -1;
    endfunction

    // Reference model: timestamps of detected edges, in clock edges.
    int n_cyc = 0;
    int r_t = 0;
    int h_t = 0;
    int e_high = 0;
    int e_period = 0;
    bit e_valid = 1'b0;
    bit e_ovf = 1'b0;
    bit armed = 1'b0;
    bit got_fall = 1'b0;
    bit hist[0:SYNC+1];
`ifdef GLITCH_FILTER_EN
    bit mf = 1'b0;
    bit mf_prev = 1'b0;
    int run = 0;
`endif

    always @(posedge clk or negedge rst_n) begin : model
        bit cur;
        bit prv;
        bit rise;
        bit fall;
        if (!rst_n) begin
            for (int i = 0; i <= SYNC + 1; i++) hist[i] = 1'b0;
            armed    = 1'b0;
            got_fall = 1'b0;
            e_high   = 0;
            e_period = 0;
            e_valid  = 1'b0;
            e_ovf    = 1'b0;
`ifdef GLITCH_FILTER_EN
            mf      = 1'b0;
            mf_prev = 1'b0;
            run     = 0;
`endif
        end else begin
            n_cyc++;
            for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = f_in;
`ifdef GLITCH_FILTER_EN
            cur     = mf;
            prv     = mf_prev;
            mf_prev = mf;
            if (hist[SYNC] != mf) begin
                run++;
                if (run == FL) begin
                    mf  = hist[SYNC];
                    run = 0;
                end
            end else begin
                run = 0;
            end
`else
            cur = hist[SYNC];
            prv = hist[SYNC+1];
`endif
            rise    = cur && !prv;
            fall    = !cur && prv;
            e_valid = 1'b0;
            if (clr) begin
                armed    = 1'b0;
                e_high   = 0;
                e_period = 0;
                e_ovf    = 1'b0;
            end else if (armed && (n_cyc - r_t) == MAXV) begin
                armed = 1'b0;
                e_ovf = 1'b1;
            end else if (rise) begin
                if (armed && got_fall) begin
                    e_high   = h_t;
                    e_period = n_cyc - r_t;
                    e_valid  = 1'b1;
                end
                armed    = 1'b1;
                got_fall = 1'b0;
                r_t      = n_cyc;
            end else if (fall && armed) begin
                got_fall = 1'b1;
                h_t      = n_cyc - r_t;
            end
        end
    end

    // Compare process: DUT against the model every cycle, and log strobes.
    always @(negedge clk) begin
        chk("high_cnt", int'(high_cnt), e_high);
        chk("period_cnt", int'(period_cnt), e_period);
        chk("meas_valid", int'(meas_valid), int'(e_valid));
        chk("overflow", int'(overflow), int'(e_ovf));
        if (meas_valid) begin
            q_high.push_back(int'(high_cnt));
            q_period.push_back(int'(period_cnt));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        f_in = 1'b1;
        cyc(hi);
        f_in = 1'b0;
        cyc(lo);
    endtask

    initial begin
        int idx;
        int sweep[4];
        sweep = '{500, 1000, 1500, 1250};

        // 0: reset state
        rst_n = 1'b0;
        cyc(3);
        #1;
        chk("rst_high", int'(high_cnt), 0);
        chk("rst_period", int'(period_cnt), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        cyc(20);

        // 1: three 2000/500 cycles -> two strobes
        idx = q_high.size();
        repeat (3) pulse(2000, 500);
        #1;
        chk("t1_strobes", q_high.size() - idx, 2);
        chk("t1_high0", qh(idx), 2000);
        chk("t1_period0", qp(idx), 2500);
        chk("t1_high1", qh(idx + 1), 2000);
        chk("t1_period1", qp(idx + 1), 2500);

        // 2: duty sweep at period 2500
        idx = q_high.size();
        for (int i = 0; i < 4; i++) pulse(sweep[i], 2500 - sweep[i]);
        f_in = 1'b1;
        cyc(10);
        #1;
        chk("t2_strobes", q_high.size() - idx, 5);
        chk("t2_high_prev", qh(idx), 2000);
        for (int i = 0; i < 4; i++) begin
            chk("t2_high", qh(idx + 1 + i), sweep[i]);
            chk("t2_period", qp(idx + 1 + i), 2500);
        end
        chk("t2_ovf", int'(overflow), 0);

        // 3: stuck high -> overflow, then re-arm and measure
        idx = q_high.size();
        cyc(65600);
        #1;
        chk("t3_ovf_set", int'(overflow), 1);
        chk("t3_no_strobe", q_high.size() - idx, 0);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(100);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(10);
        #1;
        chk("t3_strobes", q_high.size() - idx, 1);
        chk("t3_high", qh(idx), 100);
        chk("t3_period", qp(idx), 200);
        chk("t3_ovf_sticky", int'(overflow), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("t3_ovf_clr", int'(overflow), 0);

        // 4: clr in the middle of a high phase
        cyc(90);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(200);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(100);
        #1;
        chk("t4_pre_high", int'(high_cnt), 200);
        chk("t4_pre_period", int'(period_cnt), 300);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("t4_clr_high", int'(high_cnt), 0);
        chk("t4_clr_period", int'(period_cnt), 0);
        idx = q_high.size();
        cyc(99);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(200);
        #1;
        chk("t4_no_strobe", q_high.size() - idx, 0);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(10);
        #1;
        chk("t4_strobes", q_high.size() - idx, 1);
        chk("t4_high", qh(idx), 200);
        chk("t4_period", qp(idx), 300);

        // 5: two-cycle glitch inside the low phase
        cyc(190);
        f_in = 1'b0;
        idx = q_high.size();
        cyc(100);
        f_in = 1'b1;
        cyc(2);
        f_in = 1'b0;
        cyc(198);
        f_in = 1'b1;
        cyc(10);
        #1;
`ifdef GLITCH_FILTER_EN
        chk("t5_strobes", q_high.size() - idx, 1);
        chk("t5_high", qh(idx), 200);
        chk("t5_period", qp(idx), 500);
`else
        chk("t5_strobes", q_high.size() - idx, 2);
        chk("t5_high0", qh(idx), 200);
        chk("t5_period0", qp(idx), 300);
        chk("t5_high1", qh(idx + 1), 2);
        chk("t5_period1", qp(idx + 1), 200);
`endif

        // 6: asynchronous reset in mid-cycle
        cyc(50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_high", int'(high_cnt), 0);
        chk("t6_period", int'(period_cnt), 0);
        chk("t6_valid", int'(meas_valid), 0);
        chk("t6_ovf", int'(overflow), 0);
        @(negedge clk);
        f_in = 1'b0;
        cyc(5);
        rst_n = 1'b1;
        idx = q_high.size();
        cyc(100);
        f_in = 1'b1;
        cyc(150);
        #1;
        chk("t6_no_strobe", q_high.size() - idx, 0);
        f_in = 1'b0;
        cyc(100);
        f_in = 1'b1;
        cyc(10);
        #1;
        chk("t6_strobes", q_high.size() - idx, 1);
        chk("t6_high_after", qh(idx), 150);
        chk("t6_period_after", qp(idx), 250);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
